// File: rtl/paralelo_serial.sv
// Serializer for the serial link TX side: sends an 8-bit symbol MSB first per 8-cycle slot, with a comma preamble after reset.
// Optional saturating comma counter on BC_counter when PS_BC_COUNTER_EN is defined.
module paralelo_serial #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned INIT_COMMAS = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       frame_out,
  output logic       active
`ifdef PS_BC_COUNTER_EN
  ,
  output logic [3:0] BC_counter
`endif
);

  typedef enum logic {ST_INIT, ST_ACTIVE} state_t;

  // A preamble length of zero would never release the link, so it is treated as one comma.
  localparam logic [3:0] INIT_EFF = (INIT_COMMAS == 0) ? 4'd1 : 4'(INIT_COMMAS);

  state_t     state_q;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_sel_q, bit_sel_d;
  logic [3:0] comma_cnt_q;
  logic       active_q;
  logic       slot_end;
  logic       xfer;

  assign slot_end  = (bit_sel_q == 3'd7);
  assign ready_out = active_q && slot_end;
  assign xfer      = valid_in && ready_out;
  assign data_out  = shreg_q[7];
  assign frame_out = (bit_sel_q == 3'd0);
  assign active    = active_q;

  always_comb begin
    bit_sel_d = bit_sel_q + 3'd1;
    shreg_d   = {shreg_q[6:0], 1'b0};
    if (slot_end) begin
      shreg_d = xfer ? data_in : COMMA;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      shreg_q   <= COMMA;
      bit_sel_q <= 3'd0;
    end else begin
      shreg_q   <= shreg_d;
      bit_sel_q <= bit_sel_d;
    end
  end

  // Preamble FSM: count completed comma slots, then open the data path for good.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= ST_INIT;
      comma_cnt_q <= 4'd0;
      active_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (slot_end) begin
            comma_cnt_q <= comma_cnt_q + 4'd1;
            if (comma_cnt_q + 4'd1 == INIT_EFF) begin
              state_q  <= ST_ACTIVE;
              active_q <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          state_q <= ST_ACTIVE;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

`ifdef PS_BC_COUNTER_EN
  logic [3:0] bc_q;
  logic       load_comma;

  assign load_comma = slot_end && !xfer;
  assign BC_counter = bc_q;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bc_q <= 4'd0;
    end else if (load_comma && (bc_q != 4'hF)) begin
      bc_q <= bc_q + 4'd1;
    end
  end
`endif

endmodule
